// File: rtl/truth_table_sweep_if.sv
// Bundle between the truth-table sweeper and the combinational function block it exercises:
// start handshake, stimulus x/y/w/z, sampled c/d/e, and the captured results.
interface truth_table_sweep_if;
   logic        start;
   logic        x, y, w, z;
   logic        c, d, e;
   logic [3:0]  idx;
   logic        busy;
   logic        done;
   logic [15:0] table_c, table_d, table_e;
   logic [4:0]  ones_c, ones_d, ones_e;

   // master is the sweeper; slave is the environment holding the function block and the requester
   modport master (
      input  start, c, d, e,
      output x, y, w, z, idx, busy, done,
      output table_c, table_d, table_e, ones_c, ones_d, ones_e
   );

   modport slave (
      output start, c, d, e,
      input  x, y, w, z, idx, busy, done,
      input  table_c, table_d, table_e, ones_c, ones_d, ones_e
   );
endinterface

// File: rtl/truth_table_sweep.sv
// Walks {x,y,w,z} through 0..15, holding each combination SETTLE cycles, and captures c/d/e
// into 16-bit truth-table words plus per-function ones counts. SETTLE must lie in 1..15.
module truth_table_sweep #(
   parameter int unsigned SETTLE = 1
) (
   input logic               clk,
   input logic               rst_n,
   truth_table_sweep_if.master bus
);

   typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_e;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   state_e      state_q;
   logic [3:0]  idx_q;
   logic [3:0]  cnt_q;
   logic [3:0]  stim_q;
   logic        busy_q;
   logic        done_q;
   logic [15:0] tab_c_q, tab_d_q, tab_e_q;
   logic [4:0]  ones_c_q, ones_d_q, ones_e_q;

   logic [3:0]  idx_d;
   logic [3:0]  cnt_d;
   logic        sample_d;

   always_comb begin
      idx_d    = idx_q + 4'd1;
      cnt_d    = cnt_q + 4'd1;
      sample_d = (cnt_q == SETTLE_LAST);
   end

   // Leaving DRIVE at idx 15 preempts the increment, so idx never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= 4'd0;
         cnt_q    <= 4'd0;
         stim_q   <= 4'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         tab_c_q  <= 16'd0;
         tab_d_q  <= 16'd0;
         tab_e_q  <= 16'd0;
         ones_c_q <= 5'd0;
         ones_d_q <= 5'd0;
         ones_e_q <= 5'd0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (bus.start) begin
                  state_q  <= DRIVE;
                  idx_q    <= 4'd0;
                  cnt_q    <= 4'd0;
                  stim_q   <= 4'd0;
                  busy_q   <= 1'b1;
                  done_q   <= 1'b0;
                  tab_c_q  <= 16'd0;
                  tab_d_q  <= 16'd0;
                  tab_e_q  <= 16'd0;
                  ones_c_q <= 5'd0;
                  ones_d_q <= 5'd0;
                  ones_e_q <= 5'd0;
               end
            end
            DRIVE: begin
               if (sample_d) begin
                  tab_c_q[idx_q] <= bus.c;
                  tab_d_q[idx_q] <= bus.d;
                  tab_e_q[idx_q] <= bus.e;
                  ones_c_q       <= ones_c_q + {4'd0, bus.c};
                  ones_d_q       <= ones_d_q + {4'd0, bus.d};
                  ones_e_q       <= ones_e_q + {4'd0, bus.e};
                  cnt_q          <= 4'd0;
                  if (idx_q == 4'd15) begin
                     state_q <= DONE;
                     stim_q  <= 4'd0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     idx_q  <= idx_d;
                     stim_q <= idx_d;
                  end
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.x       = stim_q[3];
   assign bus.y       = stim_q[2];
   assign bus.w       = stim_q[1];
   assign bus.z       = stim_q[0];
   assign bus.idx     = idx_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.table_c = tab_c_q;
   assign bus.table_d = tab_d_q;
   assign bus.table_e = tab_e_q;
   assign bus.ones_c  = ones_c_q;
   assign bus.ones_d  = ones_d_q;
   assign bus.ones_e  = ones_e_q;

endmodule
